// File: rtl/ace_pkg.sv
// rtl/ace_pkg.sv - shared CCU types for the exclusive-access monitor
// Contents:
//   am_op_e     : atomic-manager event op carried with each monitor event
//   AmStatWidth : width of the optional pass/fail statistics counters
package ace_pkg;

   typedef enum logic [1:0] {
      AM_NOP      = 2'b00,
      AM_LOAD_EX  = 2'b01,
      AM_STORE_EX = 2'b10,
      AM_STORE    = 2'b11
   } am_op_e;

   localparam int unsigned AmStatWidth = 16;

endpackage

// File: rtl/ace_ccu_excl_resv.sv
// rtl/ace_ccu_excl_resv.sv - single exclusive reservation entry (valid + line tag)
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset
//   set_i         : take a reservation on tag_i (wins over clr_i)
//   clr_i         : drop the reservation
//   tag_i         : broadcast line index; loaded on set, compared for match
//   valid_o       : reservation live
//   tag_o         : registered line index
//   match_o       : valid_o & (tag_o == tag_i)
module ace_ccu_excl_resv #(
   parameter int unsigned AmAddrWidth = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   set_i,
   input  logic                   clr_i,
   input  logic [AmAddrWidth-1:0] tag_i,
   output logic                   valid_o,
   output logic [AmAddrWidth-1:0] tag_o,
   output logic                   match_o
);

   logic                   valid_d, valid_q;
   logic [AmAddrWidth-1:0] tag_d, tag_q;

   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      if (set_i) begin
         valid_d = 1'b1;
         tag_d   = tag_i;
      end else if (clr_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
      end
   end

   assign valid_o = valid_q;
   assign tag_o   = tag_q;
   assign match_o = valid_q && (tag_q == tag_i);

endmodule

// File: rtl/ace_ccu_excl_monitor.sv
// rtl/ace_ccu_excl_monitor.sv - per-slave-port exclusive-access monitor with registered verdict
// Optional feature macro: ACE_CCU_EXCL_MON_STATS_EN (adds saturating STORE_EX pass/fail counters)
// Ports:
//   clk_i, rst_ni            : clock, synchronous active-low reset
//   ex_valid_i / ex_ready_o  : event handshake (op, line index, issuing port)
//   ex_op_i, ex_addr_i, ex_id_i
//   resp_valid_o / resp_ready_i : verdict handshake, one verdict per accepted event
//   resp_exokay_o, resp_id_o : exclusive success flag, echoed issuing port
//   resv_valid_o             : live reservation bitmap
//   stat_pass_o, stat_fail_o : (macro only) STORE_EX pass/fail counts
module ace_ccu_excl_monitor
   import ace_pkg::*;
#(
   parameter int unsigned NoSlvPorts  = 4,
   parameter int unsigned AmAddrWidth = 8,
   parameter int unsigned IdWidth     = (NoSlvPorts > 1) ? $clog2(NoSlvPorts) : 1
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   ex_valid_i,
   output logic                   ex_ready_o,
   input  logic [1:0]             ex_op_i,
   input  logic [AmAddrWidth-1:0] ex_addr_i,
   input  logic [IdWidth-1:0]     ex_id_i,
   output logic                   resp_valid_o,
   input  logic                   resp_ready_i,
   output logic                   resp_exokay_o,
   output logic [IdWidth-1:0]     resp_id_o,
`ifdef ACE_CCU_EXCL_MON_STATS_EN
   output logic [AmStatWidth-1:0] stat_pass_o,
   output logic [AmStatWidth-1:0] stat_fail_o,
`endif
   output logic [NoSlvPorts-1:0]  resv_valid_o
);

   am_op_e                 op;
   logic                   accept;
   logic                   id_ok;
   logic                   own_hit;
   logic                   pass;
   logic [NoSlvPorts-1:0]  id_sel;
   logic [NoSlvPorts-1:0]  set_vec, clr_vec;
   logic [NoSlvPorts-1:0]  valid_vec, match_vec;
   logic [AmAddrWidth-1:0] tag_vec [NoSlvPorts];

   logic                   resp_valid_d, resp_valid_q;
   logic                   resp_exokay_d, resp_exokay_q;
   logic [IdWidth-1:0]     resp_id_d, resp_id_q;

   assign op     = am_op_e'(ex_op_i);
   // Output register frees up whenever it is empty or being popped this cycle.
   assign ex_ready_o = !resp_valid_q || resp_ready_i;
   assign accept     = ex_valid_i && ex_ready_o;

   for (genvar k = 0; k < NoSlvPorts; k++) begin : g_resv
      ace_ccu_excl_resv #(
         .AmAddrWidth (AmAddrWidth)
      ) i_resv (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .set_i   (set_vec[k]),
         .clr_i   (clr_vec[k]),
         .tag_i   (ex_addr_i),
         .valid_o (valid_vec[k]),
         .tag_o   (tag_vec[k]),
         .match_o (match_vec[k])
      );
   end

   // Decode the issuer one-hot; an id beyond NoSlvPorts decodes to nothing,
   // which makes the event a table no-op with a failing verdict.
   always_comb begin
      id_sel  = '0;
      own_hit = 1'b0;
      for (int k = 0; k < NoSlvPorts; k++) begin
         if (ex_id_i == IdWidth'(k)) begin
            id_sel[k] = 1'b1;
            own_hit   = valid_vec[k] && (tag_vec[k] == ex_addr_i);
         end
      end
      id_ok = |id_sel;
   end

   assign pass = id_ok && (op == AM_STORE_EX) && own_hit;

   // Broadcast clears hit every matching entry at once; a failing STORE_EX
   // only drops the issuer's own reservation.
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (accept && id_ok) begin
         unique case (op)
            AM_LOAD_EX:  set_vec = id_sel;
            AM_STORE_EX: clr_vec = pass ? match_vec : id_sel;
            AM_STORE:    clr_vec = match_vec;
            default:     ;
         endcase
      end
   end

   always_comb begin
      resp_valid_d  = resp_valid_q;
      resp_exokay_d = resp_exokay_q;
      resp_id_d     = resp_id_q;
      if (accept) begin
         resp_valid_d  = 1'b1;
         resp_exokay_d = pass || (id_ok && (op == AM_LOAD_EX));
         resp_id_d     = ex_id_i;
      end else if (resp_ready_i) begin
         resp_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         resp_valid_q  <= 1'b0;
         resp_exokay_q <= 1'b0;
         resp_id_q     <= '0;
      end else begin
         resp_valid_q  <= resp_valid_d;
         resp_exokay_q <= resp_exokay_d;
         resp_id_q     <= resp_id_d;
      end
   end

   assign resp_valid_o  = resp_valid_q;
   assign resp_exokay_o = resp_exokay_q;
   assign resp_id_o     = resp_id_q;
   assign resv_valid_o  = valid_vec;

`ifdef ACE_CCU_EXCL_MON_STATS_EN
   logic [AmStatWidth-1:0] stat_pass_d, stat_pass_q;
   logic [AmStatWidth-1:0] stat_fail_d, stat_fail_q;

   always_comb begin
      stat_pass_d = stat_pass_q;
      stat_fail_d = stat_fail_q;
      if (accept && (op == AM_STORE_EX)) begin
         if (pass) begin
            if (stat_pass_q != '1) stat_pass_d = stat_pass_q + 1'b1;
         end else begin
            if (stat_fail_q != '1) stat_fail_d = stat_fail_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         stat_pass_q <= '0;
         stat_fail_q <= '0;
      end else begin
         stat_pass_q <= stat_pass_d;
         stat_fail_q <= stat_fail_d;
      end
   end

   assign stat_pass_o = stat_pass_q;
   assign stat_fail_o = stat_fail_q;
`endif

endmodule

// File: tb/tb_ace_ccu_excl_monitor.sv
// tb/tb_ace_ccu_excl_monitor.sv - directed self-checking bench for ace_ccu_excl_monitor
module tb_ace_ccu_excl_monitor;
   import ace_pkg::*;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       ex_valid_i;
   logic       ex_ready_o;
   logic [1:0] ex_op_i;
   logic [7:0] ex_addr_i;
   logic [1:0] ex_id_i;
   logic       resp_valid_o;
   logic       resp_ready_i;
   logic       resp_exokay_o;
   logic [1:0] resp_id_o;
   logic [3:0] resv_valid_o;
`ifdef ACE_CCU_EXCL_MON_STATS_EN
   logic [15:0] stat_pass_o;
   logic [15:0] stat_fail_o;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk_i = ~clk_i;

   ace_ccu_excl_monitor dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .ex_valid_i    (ex_valid_i),
      .ex_ready_o    (ex_ready_o),
      .ex_op_i       (ex_op_i),
      .ex_addr_i     (ex_addr_i),
      .ex_id_i       (ex_id_i),
      .resp_valid_o  (resp_valid_o),
      .resp_ready_i  (resp_ready_i),
      .resp_exokay_o (resp_exokay_o),
      .resp_id_o     (resp_id_o),
`ifdef ACE_CCU_EXCL_MON_STATS_EN
      .stat_pass_o   (stat_pass_o),
      .stat_fail_o   (stat_fail_o),
`endif
      .resv_valid_o  (resv_valid_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One event with resp_ready_i=1; verdict and table checked #1 after the accept edge.
   task automatic ev(input string tag, input logic [1:0] op, input logic [1:0] id,
                     input logic [7:0] addr, input logic exp_ok, input logic [3:0] exp_resv);
      int n;
      @(negedge clk_i);
      ex_valid_i   = 1'b1;
      ex_op_i      = op;
      ex_id_i      = id;
      ex_addr_i    = addr;
      resp_ready_i = 1'b1;
      n = 0;
      while (!ex_ready_o && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      check({tag, "_ready"}, 32'(ex_ready_o), 32'd1);
      @(posedge clk_i);
      #1;
      ex_valid_i = 1'b0;
      check({tag, "_rvalid"}, 32'(resp_valid_o), 32'd1);
      check({tag, "_exokay"}, 32'(resp_exokay_o), 32'(exp_ok));
      check({tag, "_rid"}, 32'(resp_id_o), 32'(id));
      check({tag, "_resv"}, 32'(resv_valid_o), 32'(exp_resv));
   endtask

   initial begin
      rst_ni       = 1'b0;
      ex_valid_i   = 1'b0;
      ex_op_i      = 2'b00;
      ex_addr_i    = 8'h00;
      ex_id_i      = 2'd0;
      resp_ready_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_rvalid_in_reset", 32'(resp_valid_o), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      check("rst_resv", 32'(resv_valid_o), 32'h0);
      check("rst_rvalid", 32'(resp_valid_o), 32'd0);
      check("rst_exokay", 32'(resp_exokay_o), 32'd0);
      check("rst_rid", 32'(resp_id_o), 32'd0);
      check("rst_ready", 32'(ex_ready_o), 32'd1);

      // Basic pass
      ev("basic_ldex", AM_LOAD_EX,  2'd1, 8'h3C, 1'b1, 4'b0010);
      ev("basic_stex", AM_STORE_EX, 2'd1, 8'h3C, 1'b1, 4'b0000);

      // Contention: a passing STORE_EX wipes every matching reservation
      ev("cont_ld0",  AM_LOAD_EX,  2'd0, 8'h10, 1'b1, 4'b0001);
      ev("cont_ld2",  AM_LOAD_EX,  2'd2, 8'h10, 1'b1, 4'b0101);
      ev("cont_st2",  AM_STORE_EX, 2'd2, 8'h10, 1'b1, 4'b0000);
      ev("cont_st0",  AM_STORE_EX, 2'd0, 8'h10, 1'b0, 4'b0000);

      // Intervening plain store
      ev("pst_ld3",   AM_LOAD_EX,  2'd3, 8'h55, 1'b1, 4'b1000);
      ev("pst_st0",   AM_STORE,    2'd0, 8'h55, 1'b0, 4'b0000);
      ev("pst_stx3",  AM_STORE_EX, 2'd3, 8'h55, 1'b0, 4'b0000);
      ev("pst2_ld3",  AM_LOAD_EX,  2'd3, 8'h55, 1'b1, 4'b1000);
      ev("pst2_st0",  AM_STORE,    2'd0, 8'h56, 1'b0, 4'b1000);
      ev("pst2_stx3", AM_STORE_EX, 2'd3, 8'h55, 1'b1, 4'b0000);

      // Failing STORE_EX drops only the issuer; NOP and LOAD_EX overwrite
      ev("fail_ld0",  AM_LOAD_EX,  2'd0, 8'hAA, 1'b1, 4'b0001);
      ev("fail_ld1",  AM_LOAD_EX,  2'd1, 8'hBB, 1'b1, 4'b0011);
      ev("fail_stx0", AM_STORE_EX, 2'd0, 8'hBB, 1'b0, 4'b0010);
      ev("nop1",      AM_NOP,      2'd1, 8'hBB, 1'b0, 4'b0010);
      ev("ovw_ld1",   AM_LOAD_EX,  2'd1, 8'hCC, 1'b1, 4'b0010);
      ev("ovw_stx1",  AM_STORE_EX, 2'd1, 8'hBB, 1'b0, 4'b0000);

      // Backpressure: let the last verdict drain first
      @(negedge clk_i);
      @(negedge clk_i);
      check("bp_idle_rvalid", 32'(resp_valid_o), 32'd0);
      ex_valid_i   = 1'b1;
      ex_op_i      = AM_LOAD_EX;
      ex_id_i      = 2'd2;
      ex_addr_i    = 8'h77;
      resp_ready_i = 1'b0;
      @(posedge clk_i);
      #1;
      ex_op_i = AM_STORE_EX;
      ex_id_i = 2'd3;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         check("bp_ready_low", 32'(ex_ready_o), 32'd0);
         check("bp_rvalid", 32'(resp_valid_o), 32'd1);
         check("bp_rid", 32'(resp_id_o), 32'd2);
         check("bp_exokay", 32'(resp_exokay_o), 32'd1);
         check("bp_resv", 32'(resv_valid_o), 32'b0100);
      end
      @(negedge clk_i);
      resp_ready_i = 1'b1;
      #1;
      check("bp_release_ready", 32'(ex_ready_o), 32'd1);
      @(posedge clk_i);
      #1;
      ex_valid_i = 1'b0;
      check("bp_next_rvalid", 32'(resp_valid_o), 32'd1);
      check("bp_next_rid", 32'(resp_id_o), 32'd3);
      check("bp_next_exokay", 32'(resp_exokay_o), 32'd0);
      check("bp_next_resv", 32'(resv_valid_o), 32'b0100);
      @(posedge clk_i);
      #1;
      check("bp_drain_rvalid", 32'(resp_valid_o), 32'd0);

      // Reset mid-operation with a stalled verdict and live reservations
      @(negedge clk_i);
      ex_valid_i   = 1'b1;
      ex_op_i      = AM_LOAD_EX;
      ex_id_i      = 2'd0;
      ex_addr_i    = 8'h11;
      resp_ready_i = 1'b0;
      @(posedge clk_i);
      #1;
      ex_valid_i = 1'b0;
      check("mid_rvalid_pre", 32'(resp_valid_o), 32'd1);
      check("mid_resv_pre", 32'(resv_valid_o), 32'b0101);
      @(negedge clk_i);
      rst_ni = 1'b0;
      @(posedge clk_i);
      #1;
      check("mid_rvalid_post", 32'(resp_valid_o), 32'd0);
      check("mid_resv_post", 32'(resv_valid_o), 32'b0000);
      @(negedge clk_i);
      rst_ni       = 1'b1;
      resp_ready_i = 1'b1;

`ifdef ACE_CCU_EXCL_MON_STATS_EN
      check("stat_pass_rst", 32'(stat_pass_o), 32'd0);
      check("stat_fail_rst", 32'(stat_fail_o), 32'd0);
      ev("st_ld0",  AM_LOAD_EX,  2'd0, 8'h20, 1'b1, 4'b0001);
      ev("st_sx0",  AM_STORE_EX, 2'd0, 8'h20, 1'b1, 4'b0000);
      ev("st_ld1",  AM_LOAD_EX,  2'd1, 8'h21, 1'b1, 4'b0010);
      ev("st_sx1",  AM_STORE_EX, 2'd1, 8'h21, 1'b1, 4'b0000);
      ev("st_f0",   AM_STORE_EX, 2'd0, 8'h20, 1'b0, 4'b0000);
      ev("st_f1",   AM_STORE_EX, 2'd1, 8'h21, 1'b0, 4'b0000);
      ev("st_f2",   AM_STORE_EX, 2'd2, 8'h22, 1'b0, 4'b0000);
      @(negedge clk_i);
      check("stat_pass", 32'(stat_pass_o), 32'd2);
      check("stat_fail", 32'(stat_fail_o), 32'd3);
      // Stream 65535 more failures; total 65538 must stop at 16'hFFFF
      ex_valid_i = 1'b1;
      ex_op_i    = AM_STORE_EX;
      ex_id_i    = 2'd3;
      ex_addr_i  = 8'h00;
      repeat (65535) @(posedge clk_i);
      #1;
      ex_valid_i = 1'b0;
      @(negedge clk_i);
      check("stat_fail_sat", 32'(stat_fail_o), 32'hFFFF);
      check("stat_pass_hold", 32'(stat_pass_o), 32'd2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
